// File: rtl/gate_seq_pkg.sv
// rtl/gate_seq_pkg.sv - shared types and widths for the gate op sequencer
package gate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } seq_state_t;

  localparam logic [1:0] OP_00 = 2'b00;
  localparam logic [1:0] OP_01 = 2'b01;
  localparam logic [1:0] OP_10 = 2'b10;
  localparam logic [1:0] OP_11 = 2'b11;

  localparam int OP_W  = 2;
  localparam int A_W   = 4;
  localparam int B_W   = 2;
  localparam int Y_W   = 4;
  localparam int CMD_W = OP_W + A_W + B_W;

  function automatic logic [CMD_W-1:0] pack_cmd(
    input logic [OP_W-1:0] op,
    input logic [A_W-1:0]  a,
    input logic [B_W-1:0]  b
  );
    return {op, a, b};
  endfunction

endpackage

// File: rtl/gate_seq_fifo.sv
// rtl/gate_seq_fifo.sv - command FIFO with wrap-bit pointers and show-ahead read
module gate_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bits means the writer lapped the reader.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gate_op_sequencer.sv
// rtl/gate_op_sequencer.sv - queues gate ops, drives the controller, returns Y (GATE_SEQ_STATS_EN adds op_count)
module gate_op_sequencer
  import gate_seq_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_op,
  input  logic [A_W-1:0]  cmd_a,
  input  logic [B_W-1:0]  cmd_b,
  output logic            ctl_i,
  output logic            ctl_s1,
  output logic            ctl_s0,
  output logic [A_W-1:0]  ctl_a,
  output logic [B_W-1:0]  ctl_b,
  input  logic [Y_W-1:0]  ctl_y,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [Y_W-1:0]  rsp_y,
  output logic [OP_W-1:0] rsp_op,
  output logic            busy
`ifdef GATE_SEQ_STATS_EN
  ,
  output logic [15:0]     op_count
`endif
);

  seq_state_t       state;
  logic [3:0]       settle_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [CMD_W-1:0] fifo_rdata;

  assign cmd_ready = rst_n && !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign busy      = (state != IDLE) || !fifo_empty;

  gate_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (pack_cmd(cmd_op, cmd_a, cmd_b)),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      ctl_i      <= 1'b0;
      ctl_s1     <= 1'b0;
      ctl_s0     <= 1'b0;
      ctl_a      <= '0;
      ctl_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_y      <= '0;
      rsp_op     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            ctl_s1     <= fifo_rdata[CMD_W-1];
            ctl_s0     <= fifo_rdata[CMD_W-2];
            ctl_a      <= fifo_rdata[B_W +: A_W];
            ctl_b      <= fifo_rdata[B_W-1:0];
            ctl_i      <= 1'b1;
            settle_cnt <= 4'(SETTLE_CYCLES);
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          // Sample Y on the edge that closes the last settle cycle.
          if (settle_cnt == 4'd1) begin
            rsp_y     <= ctl_y;
            rsp_op    <= {ctl_s1, ctl_s0};
            rsp_valid <= 1'b1;
            ctl_i     <= 1'b0;
            state     <= RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          ctl_i     <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef GATE_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (rsp_valid && rsp_ready) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gate_op_sequencer.sv
// tb/tb_gate_op_sequencer.sv - directed self-checking bench for gate_op_sequencer
module tb_gate_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cmd_valid, cmd_ready, ctl_i, ctl_s1, ctl_s0;
  logic       rsp_valid, rsp_ready, busy;
  logic [1:0] cmd_op, cmd_b, ctl_b, rsp_op;
  logic [3:0] cmd_a, ctl_a, ctl_y, rsp_y;

  logic       rst3_n, cmd_valid3, cmd_ready3, ctl_i3, ctl_s13, ctl_s03;
  logic       rsp_valid3, rsp_ready3, busy3;
  logic [1:0] cmd_op3, cmd_b3, ctl_b3, rsp_op3;
  logic [3:0] cmd_a3, ctl_a3, y3, rsp_y3;

`ifdef GATE_SEQ_STATS_EN
  logic [15:0] op_count, op_count3;
`endif

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [3:0] gate_y(input logic [1:0] op, input logic [3:0] a, input logic [1:0] b);
    case (op)
      2'b00:   return a & {b, b};
      2'b01:   return a | {b, b};
      2'b10:   return a ^ {b, b};
      default: return ~a;
    endcase
  endfunction

  assign ctl_y = gate_y({ctl_s1, ctl_s0}, ctl_a, ctl_b);

  gate_op_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .ctl_i(ctl_i), .ctl_s1(ctl_s1), .ctl_s0(ctl_s0), .ctl_a(ctl_a), .ctl_b(ctl_b),
    .ctl_y(ctl_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_op(rsp_op), .busy(busy)
`ifdef GATE_SEQ_STATS_EN
    , .op_count(op_count)
`endif
  );

  gate_op_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op3), .cmd_a(cmd_a3), .cmd_b(cmd_b3),
    .ctl_i(ctl_i3), .ctl_s1(ctl_s13), .ctl_s0(ctl_s03), .ctl_a(ctl_a3), .ctl_b(ctl_b3),
    .ctl_y(y3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_y(rsp_y3), .rsp_op(rsp_op3), .busy(busy3)
`ifdef GATE_SEQ_STATS_EN
    , .op_count(op_count3)
`endif
  );

  logic [5:0] rsp_q[$];
  int         rsp3_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) rsp_q.push_back({rsp_op, rsp_y});
    if (rst3_n && rsp_valid3 && rsp_ready3) rsp3_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [1:0] b);
    bit ok;
    ok = 1'b0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      ok = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int t = 0; t < 200 && busy; t++) tick();
    check(tag, 32'(busy), 32'd0);
  endtask

  logic [1:0] t3_op [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
  logic [3:0] t3_a  [6] = '{4'b0011, 4'b1000, 4'b1111, 4'b0110, 4'b1100, 4'b0000};
  logic [5:0] t3_exp[5] = '{6'h01, 6'h1D, 6'h2A, 6'h39, 6'h04};
  logic [5:0] t2_exp[4] = '{6'h0A, 6'h1E, 6'h24, 6'h31};

  initial begin
    int base, acc, acc_at_drop, hi, base3;
    bit r;
    rst_n = 0; cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; rsp_ready = 0;
    rst3_n = 0; cmd_valid3 = 0; cmd_op3 = 0; cmd_a3 = 0; cmd_b3 = 0; rsp_ready3 = 0; y3 = 0;
    tick(); tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_op, rsp_y}), 32'd0);
    check("rst_ctl", 32'({ctl_i, ctl_s1, ctl_s0, ctl_a, ctl_b}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1; rst3_n = 1;
    tick();
    check("ready_after_rst", 32'({cmd_ready, cmd_ready3}), 32'b11);

    // Single op, settle 1: accept at N, drive N+1, response after N+2.
    rsp_ready = 1;
    cmd_op = 2'b00; cmd_a = 4'b1110; cmd_b = 2'b10; cmd_valid = 1;
    tick();
    cmd_valid = 0;
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ctl_i_pre", 32'(ctl_i), 32'd0);
    tick();
    check("t1_drive", 32'({ctl_i, ctl_s1, ctl_s0, ctl_a, ctl_b}), 32'({1'b1, 2'b00, 4'b1110, 2'b10}));
    check("t1_no_rsp_yet", 32'(rsp_valid), 32'd0);
    tick();
    check("t1_ctl_i_off", 32'(ctl_i), 32'd0);
    check("t1_ctl_hold", 32'({ctl_s1, ctl_s0, ctl_a, ctl_b}), 32'({2'b00, 4'b1110, 2'b10}));
    check("t1_rsp", 32'({rsp_valid, rsp_op, rsp_y}), 32'({1'b1, 2'b00, 4'hA}));
    tick();
    check("t1_done", 32'({rsp_valid, busy}), 32'd0);

    // Four back-to-back ops.
    base = rsp_q.size();
    for (int k = 0; k < 4; k++) send(2'(k), 4'b1110, 2'b10);
    wait_idle("t2_busy_falls");
    check("t2_count", 32'(rsp_q.size() - base), 32'd4);
    for (int k = 0; k < 4 && base + k < rsp_q.size(); k++)
      check($sformatf("t2_rsp%0d", k), 32'(rsp_q[base + k]), 32'(t2_exp[k]));

    // Backpressure: 4 queued + 1 stalled in RESP, then drain in order.
    rsp_ready = 0;
    base = rsp_q.size();
    acc = 0; acc_at_drop = -1;
    cmd_valid = 1;
    for (int c = 0; c < 10; c++) begin
      if (acc < 6) begin cmd_op = t3_op[acc]; cmd_a = t3_a[acc]; cmd_b = 2'b01; end
      if (!cmd_ready && acc_at_drop < 0) acc_at_drop = acc;
      r = cmd_ready;
      tick();
      if (r) acc++;
    end
    cmd_valid = 0;
    check("t3_accepts", 32'(acc), 32'd5);
    check("t3_drop_after", 32'(acc_at_drop), 32'd5);
    check("t3_stalled", 32'({rsp_valid, cmd_ready}), 32'b10);
    rsp_ready = 1;
    wait_idle("t3_drain_idle");
    check("t3_count", 32'(rsp_q.size() - base), 32'd5);
    for (int k = 0; k < 5 && base + k < rsp_q.size(); k++)
      check($sformatf("t3_rsp%0d", k), 32'(rsp_q[base + k]), 32'(t3_exp[k]));

    // Settle 3: Y changed in drive cycle 3 is captured, change in cycle 4 is not.
    rsp_ready3 = 0; y3 = 4'h5; hi = 0;
    cmd_op3 = 2'b10; cmd_a3 = 4'b0101; cmd_b3 = 2'b11; cmd_valid3 = 1;
    tick();
    cmd_valid3 = 0;
    tick(); hi += int'(ctl_i3);
    tick(); hi += int'(ctl_i3);
    tick(); hi += int'(ctl_i3);
    y3 = 4'hC;
    tick(); hi += int'(ctl_i3);
    check("t4_ctl_i_cycles", 32'(hi), 32'd3);
    check("t4_rsp", 32'({rsp_valid3, rsp_op3, rsp_y3}), 32'({1'b1, 2'b10, 4'hC}));
    y3 = 4'h3;
    tick();
    check("t4_rsp_hold", 32'({rsp_valid3, rsp_y3}), 32'({1'b1, 4'hC}));
    rsp_ready3 = 1;
    tick();
    check("t4_done", 32'(rsp_valid3), 32'd0);

    // Reset mid-DRIVE with two queued: everything discarded.
    base3 = rsp3_cnt;
    cmd_valid3 = 1;
    for (int k = 0; k < 3; k++) begin
      cmd_op3 = 2'(k); cmd_a3 = 4'(k + 1); cmd_b3 = 2'b01;
      tick();
    end
    cmd_valid3 = 0;
    check("t5_in_drive", 32'({ctl_i3, busy3}), 32'b11);
    rst3_n = 0;
    tick();
    check("t5_rst_outputs", 32'({ctl_i3, rsp_valid3, busy3, cmd_ready3}), 32'd0);
    rst3_n = 1;
    repeat (12) tick();
    check("t5_no_stale_rsp", 32'(rsp3_cnt - base3), 32'd0);
    check("t5_idle", 32'(busy3), 32'd0);

`ifdef GATE_SEQ_STATS_EN
    rst_n = 0; tick(); rst_n = 1; tick();
    check("t6_count_rst", 32'(op_count), 32'd0);
    rsp_ready = 1;
    for (int k = 0; k < 3; k++) send(2'(k), 4'b1010, 2'b01);
    wait_idle("t6_idle");
    check("t6_count3", 32'(op_count), 32'd3);
    rst_n = 0; tick();
    check("t6_count_reset", 32'(op_count), 32'd0);
    rst_n = 1; tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
